branch_predictor_tables: RTL

- Consumer end of the predictor_update interface driven by the branch-resolve unit.
- Holds a direct-mapped BTB (tag, target, valid) and a 2-bit saturating-counter BHT.
- Applies resolved-branch updates and serves registered taken/target predictions to the fetch stage.
- After reset, clears its tables with an init walker before it accepts any update.

---
 rtl/branch_predictor_tables_pkg.sv | 33 +++
 rtl/sat_counter2.sv | 22 ++
 rtl/branch_predictor_tables.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/branch_predictor_tables_pkg.sv
// Shared types for the branch predictor tables.
//   predictor_update : resolved-branch record sent by the branch-resolve unit
//   bht_state_t      : 2-bit saturating counter encoding (MSB = predict taken)
//   bp_fsm_t         : table controller state (INIT clears tables, READY serves)
package branch_predictor_tables_pkg;

  localparam int unsigned BP_PC_W     = 32;
  localparam int unsigned BP_TICKET_W = 6;
  localparam int unsigned BP_RAT_W    = 3;

  typedef struct packed {
    logic                   valid_jump;
    logic                   jump_taken;
    logic                   is_comp;
    logic [BP_PC_W-1:0]     orig_pc;
    logic [BP_PC_W-1:0]     jump_address;
    logic [BP_TICKET_W-1:0] ticket;
    logic [BP_RAT_W-1:0]    rat_id;
  } predictor_update;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_state_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_fsm_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
//   cnt_i   : current counter value
//   taken_i : resolved direction (1 = taken)
//   cnt_o   : counter after the update, clamped to SNT..ST
module sat_counter2
  import branch_predictor_tables_pkg::*;
(
  input  bht_state_t cnt_i,
  input  logic       taken_i,
  output bht_state_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = bht_state_t'(cnt_i + 2'd1);
    end else begin
      if (cnt_i != SNT) cnt_o = bht_state_t'(cnt_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor_tables.sv
// Direct-mapped BTB plus 2-bit counter BHT with a reset-time clear walker.
//   clk, rst_n  : clock, synchronous active-low reset
//   pr_update   : resolved-branch update (captured one edge, applied the next)
//   fetch_valid : fetch requests a prediction for fetch_pc
//   fetch_pc    : PC to predict
//   pred_valid  : BTB hit for the previously registered fetch PC
//   pred_taken  : BHT counter MSB, qualified by the hit
//   pred_target : BTB target on hit, otherwise 0
//   init_busy   : tables are being cleared, updates are dropped
// Optional build macro BP_GSHARE_EN: XOR a global history register into the
// BHT index (BTB stays PC-indexed).
module branch_predictor_tables
  import branch_predictor_tables_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned HIST_BITS  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  predictor_update     pr_update,
  input  logic                fetch_valid,
  input  logic [PC_BITS-1:0]  fetch_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [PC_BITS-1:0]  pred_target,
  output logic                init_busy
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  logic                btb_valid_q [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q   [ENTRIES];
  logic [PC_BITS-1:0]  btb_tgt_q   [ENTRIES];
  bht_state_t          bht_q       [ENTRIES];

  bp_fsm_t               state_q;
  logic [INDEX_BITS-1:0] walk_q;

  logic               upd_vld_q;
  logic               upd_taken_q;
  logic [PC_BITS-1:0] upd_pc_q;
  logic [PC_BITS-1:0] upd_tgt_q;

  logic [INDEX_BITS-1:0] f_idx, f_bidx, u_idx, u_bidx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  rd_hit;
  logic [1:0]            bht_rd;
  bht_state_t            bht_d;

  // Halfword granularity: bit 0 is skipped so compressed branches get a slot.
  assign f_idx = fetch_pc[INDEX_BITS:1];
  assign f_tag = fetch_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
  assign u_idx = upd_pc_q[INDEX_BITS:1];
  assign u_tag = upd_pc_q[INDEX_BITS+TAG_BITS:INDEX_BITS+1];

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q;
  assign f_bidx = f_idx ^ INDEX_BITS'(ghr_q);
  assign u_bidx = u_idx ^ INDEX_BITS'(ghr_q);
`else
  logic [HIST_BITS-1:0] unused_hist;
  assign unused_hist = '0;
  assign f_bidx = f_idx;
  assign u_bidx = u_idx;
`endif

  assign rd_hit = (state_q == READY) && fetch_valid && btb_valid_q[f_idx]
                  && (btb_tag_q[f_idx] == f_tag);
  assign bht_rd = bht_q[f_bidx];
  assign init_busy = (state_q == INIT);

  sat_counter2 u_sat (
    .cnt_i   (bht_q[u_bidx]),
    .taken_i (upd_taken_q),
    .cnt_o   (bht_d)
  );

  // Controller: INIT walker, update-valid stage and registered predictions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      walk_q      <= '0;
      upd_vld_q   <= 1'b0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
`ifdef BP_GSHARE_EN
      ghr_q       <= '0;
`endif
    end else begin
      if (state_q == INIT) begin
        walk_q <= walk_q + 1'b1;
        if (walk_q == LAST_IDX) state_q <= READY;
`ifdef BP_GSHARE_EN
        ghr_q <= '0;
`endif
      end
`ifdef BP_GSHARE_EN
      else if (upd_vld_q) begin
        ghr_q <= {ghr_q[HIST_BITS-2:0], upd_taken_q};
      end
`endif
      upd_vld_q   <= (state_q == READY) && pr_update.valid_jump;
      pred_valid  <= rd_hit;
      pred_taken  <= rd_hit & bht_rd[1];
      pred_target <= rd_hit ? btb_tgt_q[f_idx] : '0;
    end
  end

  // Update payload: only meaningful while upd_vld_q is set, so no reset.
  always_ff @(posedge clk) begin
    if (pr_update.valid_jump) begin
      upd_taken_q <= pr_update.jump_taken;
      upd_pc_q    <= PC_BITS'(pr_update.orig_pc);
      upd_tgt_q   <= PC_BITS'(pr_update.jump_address);
    end
  end

  // Tables: cleared by the walker, written by the apply stage. The fetch
  // read above uses the pre-write contents on a same-edge collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        btb_valid_q[walk_q] <= 1'b0;
        bht_q[walk_q]       <= WNT;
      end else if (upd_vld_q) begin
        bht_q[u_bidx] <= bht_d;
        if (upd_taken_q) begin
          btb_valid_q[u_idx] <= 1'b1;
          btb_tag_q[u_idx]   <= u_tag;
          btb_tgt_q[u_idx]   <= upd_tgt_q;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pr_update.is_comp, pr_update.ticket, pr_update.rat_id,
                         fetch_pc[PC_BITS-1:INDEX_BITS+TAG_BITS+1], fetch_pc[0],
                         upd_pc_q[PC_BITS-1:INDEX_BITS+TAG_BITS+1], upd_pc_q[0]};

endmodule
